mem_arbiter: RTL and testbench

Shares the single 2-bit-wide instruction/data RAM between the instruction-fetch port and the load/store (MEM) port. It sequences every byte access as four RAM beats and assembles or splits the byte. It sits between the CPU front/back ends and the RAM, and replaces each requester's private RAM sequencing. One access is in flight at a time.

---
 rtl/mem_arb_pkg.sv | 28 ++
 rtl/mem_arbiter_if.sv | 53 +++++
 rtl/mem_arb_pick.sv | 41 ++++
 rtl/mem_arbiter.sv | 158 +++++++++++++++
 tb/tb_mem_arbiter.sv | 332 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mem_arb_pkg
// Purpose : Shared types and constants for the mem_arbiter slice:
//           - FSM state encoding (IDLE / ISSUE / DRAIN / DONE)
//           - beat count per byte access and beat counter width
//           - grant identifiers for the two requesters
// Ports   : none (package)
// Macro   : none
// Revision: 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int BEATS      = 4;
  localparam int BEAT_CNT_W = 2;

  localparam logic GNT_IF  = 1'b0;
  localparam logic GNT_MEM = 1'b1;

endpackage : mem_arb_pkg
`default_nettype wire

// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module  : mem_arbiter_if
// Purpose : Bundles the fetch port, the load/store port, the RAM port and the
//           busy flag of mem_arbiter.
// Ports   : if_req/if_addr -> if_done/if_rdata          (fetch requester)
//           mem_req/mem_we/mem_addr/mem_wdata -> mem_done/mem_rdata
//           ram_ce/ram_we/ram_addr/ram_din -> RAM, ram_dout <- RAM
//           busy                                          (status)
// Modports: slave  - the arbiter
//           master - the environment (requesters and RAM)
// Macro   : none
// Revision: 1.0 - initial release
// ============================================================================
interface mem_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8,
  parameter int BEAT_W = 2
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_done;
  logic [DATA_W-1:0] if_rdata;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_done;
  logic [DATA_W-1:0] mem_rdata;

  logic              ram_ce;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [BEAT_W-1:0] ram_din;
  logic [BEAT_W-1:0] ram_dout;

  logic              busy;

  modport slave (
    input  if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, ram_dout,
    output if_done, if_rdata, mem_done, mem_rdata,
           ram_ce, ram_we, ram_addr, ram_din, busy
  );

  modport master (
    output if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, ram_dout,
    input  if_done, if_rdata, mem_done, mem_rdata,
           ram_ce, ram_we, ram_addr, ram_din, busy
  );

endinterface : mem_arbiter_if
`default_nettype wire

// File: rtl/mem_arb_pick.sv
`default_nettype none
// ============================================================================
// Module  : mem_arb_pick
// Purpose : Two-way request picker. Output is only meaningful when at least
//           one request is active.
// Ports   : req_if_i   - fetch request
//           req_mem_i  - load/store request
//           last_gnt_i - port granted most recently (round-robin only)
//           gnt_o      - winning grant ID (GNT_IF / GNT_MEM)
// Macro   : MEM_ARB_RR_EN - defined: round-robin; undefined: MEM has fixed
//           priority over IF.
// Revision: 1.0 - initial release
// ============================================================================
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic req_if_i,
  input  logic req_mem_i,
  input  logic last_gnt_i,
  output logic gnt_o
);

`ifdef MEM_ARB_RR_EN
  // On a tie the port that did not win last time gets the grant.
  always_comb begin
    gnt_o = GNT_IF;
    if (req_if_i && req_mem_i) begin
      gnt_o = (last_gnt_i == GNT_IF) ? GNT_MEM : GNT_IF;
    end else if (req_mem_i) begin
      gnt_o = GNT_MEM;
    end
  end
`else
  // With fixed priority only the MEM request decides the outcome.
  logic w_unused_pick;
  assign w_unused_pick = req_if_i | last_gnt_i;
  assign gnt_o         = req_mem_i ? GNT_MEM : GNT_IF;
`endif

endmodule : mem_arb_pick
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : mem_arbiter
// Purpose : Shares a 2-bit-wide RAM between the instruction-fetch port and the
//           load/store port. Each byte access runs as four RAM beats
//           (low beat first); read beats are reassembled into a byte.
//           One access is in flight at a time.
// Ports   : clk    - clock, posedge
//           rst_n  - asynchronous active-low reset
//           bus    - mem_arbiter_if.slave (requester ports, RAM port, busy)
// Macro   : MEM_ARB_RR_EN - round-robin arbitration on simultaneous requests;
//           without it MEM has fixed priority over IF.
// Revision: 1.0 - initial release
// ============================================================================
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8,
  parameter int BEAT_W = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  mem_arbiter_if.slave  bus
);

  localparam logic [BEAT_CNT_W-1:0] LAST_BEAT = BEAT_CNT_W'(BEATS - 1);
  localparam int                    SHIFT_W   = DATA_W - BEAT_W;

  state_e                state_q, state_d;
  logic [BEAT_CNT_W-1:0] beat_q, beat_d;
  logic                  gnt_q, gnt_d;
  logic                  we_q, we_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  // Holds beats 0..2 of a read; beat 3 arrives straight from the RAM in DRAIN.
  logic [SHIFT_W-1:0]    shift_q, shift_d;
  logic [DATA_W-1:0]     if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]     mem_rdata_q, mem_rdata_d;

  logic                  gnt_pick;
  logic                  last_gnt;
  logic [DATA_W-1:0]     assembled;

`ifdef MEM_ARB_RR_EN
  logic last_gnt_q, last_gnt_d;
  assign last_gnt = last_gnt_q;
`else
  assign last_gnt = GNT_IF;
`endif

  mem_arb_pick u_pick (
    .req_if_i   (bus.if_req),
    .req_mem_i  (bus.mem_req),
    .last_gnt_i (last_gnt),
    .gnt_o      (gnt_pick)
  );

  assign assembled = {bus.ram_dout, shift_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      beat_q      <= '0;
      gnt_q       <= GNT_IF;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      shift_q     <= '0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
`ifdef MEM_ARB_RR_EN
      last_gnt_q  <= GNT_IF;
`endif
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      gnt_q       <= gnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      shift_q     <= shift_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
`ifdef MEM_ARB_RR_EN
      last_gnt_q  <= last_gnt_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    gnt_d       = gnt_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    shift_d     = shift_q;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
`ifdef MEM_ARB_RR_EN
    last_gnt_d  = last_gnt_q;
`endif

    case (state_q)
      IDLE: begin
        if (bus.if_req || bus.mem_req) begin
          gnt_d   = gnt_pick;
          addr_d  = (gnt_pick == GNT_MEM) ? bus.mem_addr : bus.if_addr;
          we_d    = (gnt_pick == GNT_MEM) && bus.mem_we;
          wdata_d = (gnt_pick == GNT_MEM) ? bus.mem_wdata : '0;
          beat_d  = '0;
          state_d = ISSUE;
`ifdef MEM_ARB_RR_EN
          last_gnt_d = gnt_pick;
`endif
        end
      end
      ISSUE: begin
        // RAM latency is one cycle, so in beat k the RAM returns beat k-1.
        if (!we_q && (beat_q != '0)) begin
          shift_d = {bus.ram_dout, shift_q[SHIFT_W-1:BEAT_W]};
        end
        if (beat_q == LAST_BEAT) begin
          state_d = we_q ? DONE : DRAIN;
        end else begin
          beat_d = beat_q + 1'b1;
        end
      end
      DRAIN: begin
        if (gnt_q == GNT_IF) begin
          if_rdata_d = assembled;
        end else begin
          mem_rdata_d = assembled;
        end
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.ram_ce    = (state_q == ISSUE);
  assign bus.ram_we    = (state_q == ISSUE) && we_q;
  assign bus.ram_addr  = (state_q == ISSUE) ? (addr_q + ADDR_W'(beat_q)) : '0;
  assign bus.ram_din   = (state_q == ISSUE) ? wdata_q[beat_q*BEAT_W +: BEAT_W] : '0;
  assign bus.busy      = (state_q != IDLE);
  assign bus.if_done   = (state_q == DONE) && (gnt_q == GNT_IF);
  assign bus.mem_done  = (state_q == DONE) && (gnt_q == GNT_MEM);
  assign bus.if_rdata  = if_rdata_q;
  assign bus.mem_rdata = mem_rdata_q;

endmodule : mem_arbiter
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_mem_arbiter
// Purpose : Self-checking bench for mem_arbiter with a 2-bit RAM model and a
//           completion scoreboard (expected done port, cycle and read data).
// Macro   : MEM_ARB_RR_EN - selects the expected winner of the second tie.
// Revision: 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(16), .DATA_W(8), .BEAT_W(2)) bus ();

  mem_arbiter #(.ADDR_W(16), .DATA_W(8), .BEAT_W(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // RAM model: registered read, one cycle after ram_ce.
  logic [1:0] ram [0:65535];
  always @(posedge clk) begin
    if (bus.ram_ce) begin
      if (bus.ram_we) ram[bus.ram_addr] <= bus.ram_din;
      else            bus.ram_dout      <= ram[bus.ram_addr];
    end
  end

  logic [31:0] cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        port;
    logic        rd;
    logic [7:0]  data;
    logic [31:0] cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  logic [7:0] mon_rdata;

  // Scoreboard consumer: every done pulse must match the next expected entry.
  always @(negedge clk) begin
    if (bus.if_done || bus.mem_done) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: if_done=%0b mem_done=%0b cyc=%0d (none expected)",
                 bus.if_done, bus.mem_done, cyc);
      end else begin
        mon_e = sb.pop_front();
        checks++;
        if ({bus.mem_done, bus.if_done} !== (mon_e.port ? 2'b10 : 2'b01)) begin
          errors++;
          $display("FAIL done_port: got {mem,if}=%b expected port %0d",
                   {bus.mem_done, bus.if_done}, mon_e.port);
        end
        checks++;
        if (cyc !== mon_e.cyc) begin
          errors++;
          $display("FAIL done_cycle: got %0d expected %0d", cyc, mon_e.cyc);
        end
        if (mon_e.rd) begin
          mon_rdata = mon_e.port ? bus.mem_rdata : bus.if_rdata;
          checks++;
          if (mon_rdata !== mon_e.data) begin
            errors++;
            $display("FAIL rdata: port %0d got %h expected %h", mon_e.port, mon_rdata, mon_e.data);
          end
        end
      end
    end
  end

  task automatic wait_idle();
    for (int i = 0; i < 40 && bus.busy; i++) @(negedge clk);
    if (bus.busy) begin
      checks++; errors++;
      $display("FAIL idle_timeout: busy=%0b expected 0", bus.busy);
    end
  endtask

  task automatic wait_done_any(output logic port);
    bit ok;
    ok   = 1'b0;
    port = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.if_done || bus.mem_done) begin
        port = bus.mem_done;
        ok   = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL done_timeout: no done within 30 cycles, expected 1");
    end
  endtask

  task automatic drop_req(input logic port);
    if (port == GNT_MEM) bus.mem_req = 1'b0;
    else                 bus.if_req  = 1'b0;
  endtask

  task automatic single_read(input logic port, input logic [15:0] addr, input logic [7:0] exp);
    logic p;
    wait_idle();
    if (port == GNT_MEM) begin
      bus.mem_we = 1'b0; bus.mem_addr = addr; bus.mem_req = 1'b1;
    end else begin
      bus.if_addr = addr; bus.if_req = 1'b1;
    end
    sb.push_back(exp_t'{port, 1'b1, exp, cyc + 32'd6});
    wait_done_any(p);
    drop_req(port);
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({bus.busy, bus.ram_ce, bus.ram_we, bus.if_done, bus.mem_done} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 00000",
               {bus.busy, bus.ram_ce, bus.ram_we, bus.if_done, bus.mem_done});
    end
    checks++;
    if (bus.ram_addr !== 16'h0) begin
      errors++; $display("FAIL reset_ram_addr: got %h expected 0000", bus.ram_addr);
    end
    checks++;
    if (bus.ram_din !== 2'b0) begin
      errors++; $display("FAIL reset_ram_din: got %b expected 00", bus.ram_din);
    end
    checks++;
    if ({bus.if_rdata, bus.mem_rdata} !== 16'h0) begin
      errors++; $display("FAIL reset_rdata: got %h/%h expected 00/00", bus.if_rdata, bus.mem_rdata);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_if_read();
    logic p;
    ram[0] = 2'b01; ram[1] = 2'b10; ram[2] = 2'b11; ram[3] = 2'b11;
    wait_idle();
    bus.if_addr = 16'h0000; bus.if_req = 1'b1;
    sb.push_back(exp_t'{GNT_IF, 1'b1, 8'hF9, cyc + 32'd6});
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if ({bus.ram_ce, bus.ram_we, bus.ram_addr} !== {1'b1, 1'b0, 16'(k)}) begin
        errors++;
        $display("FAIL if_beat%0d: got ce=%0b we=%0b addr=%h expected 1 0 %h",
                 k, bus.ram_ce, bus.ram_we, bus.ram_addr, 16'(k));
      end
    end
    @(negedge clk);
    checks++;
    if ({bus.ram_ce, bus.ram_we, bus.busy} !== 3'b001) begin
      errors++;
      $display("FAIL drain_ctrl: got ce/we/busy=%b expected 001", {bus.ram_ce, bus.ram_we, bus.busy});
    end
    wait_done_any(p);
    drop_req(GNT_IF);
  endtask

  task automatic test_write_read();
    logic       p;
    logic [7:0] w;
    w = 8'hA5;
    wait_idle();
    bus.mem_we = 1'b1; bus.mem_addr = 16'h0004; bus.mem_wdata = w; bus.mem_req = 1'b1;
    sb.push_back(exp_t'{GNT_MEM, 1'b0, 8'h00, cyc + 32'd5});
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if ({bus.ram_ce, bus.ram_we, bus.ram_addr, bus.ram_din} !==
          {1'b1, 1'b1, 16'(4 + k), w[2*k +: 2]}) begin
        errors++;
        $display("FAIL wr_beat%0d: got ce=%0b we=%0b addr=%h din=%b expected 1 1 %h %b",
                 k, bus.ram_ce, bus.ram_we, bus.ram_addr, bus.ram_din, 16'(4 + k), w[2*k +: 2]);
      end
    end
    wait_done_any(p);
    drop_req(GNT_MEM);
    checks++;
    if ({ram[7], ram[6], ram[5], ram[4]} !== 8'hA5) begin
      errors++;
      $display("FAIL ram_content: got %h expected a5", {ram[7], ram[6], ram[5], ram[4]});
    end
    single_read(GNT_MEM, 16'h0004, 8'hA5);
  endtask

  task automatic test_wrap();
    logic        p;
    logic [15:0] a;
    ram[16'hFFFE] = 2'b11; ram[16'hFFFF] = 2'b00; ram[0] = 2'b01; ram[1] = 2'b10;
    wait_idle();
    bus.if_addr = 16'hFFFE; bus.if_req = 1'b1;
    sb.push_back(exp_t'{GNT_IF, 1'b1, 8'h93, cyc + 32'd6});
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      a = 16'hFFFE + 16'(k);
      checks++;
      if (bus.ram_addr !== a) begin
        errors++; $display("FAIL wrap_addr%0d: got %h expected %h", k, bus.ram_addr, a);
      end
    end
    wait_done_any(p);
    drop_req(GNT_IF);
  endtask

  task automatic test_tie(input logic exp_first);
    logic p;
    ram[0] = 2'b01; ram[1] = 2'b10; ram[2] = 2'b11; ram[3] = 2'b11;
    ram[4] = 2'b10; ram[5] = 2'b01; ram[6] = 2'b01; ram[7] = 2'b10;
    wait_idle();
    bus.if_addr  = 16'h0004; bus.if_req = 1'b1;
    bus.mem_addr = 16'h0000; bus.mem_we = 1'b0; bus.mem_req = 1'b1;
    if (exp_first == GNT_MEM) begin
      sb.push_back(exp_t'{GNT_MEM, 1'b1, 8'hF9, cyc + 32'd6});
      sb.push_back(exp_t'{GNT_IF,  1'b1, 8'h96, cyc + 32'd13});
    end else begin
      sb.push_back(exp_t'{GNT_IF,  1'b1, 8'h96, cyc + 32'd6});
      sb.push_back(exp_t'{GNT_MEM, 1'b1, 8'hF9, cyc + 32'd13});
    end
    wait_done_any(p);
    checks++;
    if (p !== exp_first) begin
      errors++; $display("FAIL tie_winner: got port %0d expected %0d", p, exp_first);
    end
    drop_req(p);
    wait_done_any(p);
    drop_req(p);
  endtask

  task automatic test_reset_midflight();
    wait_idle();
    bus.if_addr = 16'h0000; bus.if_req = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.ram_ce, bus.ram_addr} !== {1'b1, 16'h0002}) begin
      errors++;
      $display("FAIL mid_beat2: got ce=%0b addr=%h expected 1 0002", bus.ram_ce, bus.ram_addr);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.ram_ce, bus.busy, bus.if_done, bus.mem_done} !== 4'b0) begin
      errors++;
      $display("FAIL mid_reset_ctrl: got ce/busy/ifd/memd=%b expected 0000",
               {bus.ram_ce, bus.busy, bus.if_done, bus.mem_done});
    end
    checks++;
    if ({bus.if_rdata, bus.mem_rdata} !== 16'h0) begin
      errors++;
      $display("FAIL mid_reset_rdata: got %h/%h expected 00/00", bus.if_rdata, bus.mem_rdata);
    end
    bus.if_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    single_read(GNT_IF, 16'h0000, 8'hF9);
  endtask

  task automatic test_back_to_back();
    logic p;
    ram[0] = 2'b01; ram[1] = 2'b10; ram[2] = 2'b11; ram[3] = 2'b11;
    wait_idle();
    bus.if_addr = 16'h0000; bus.if_req = 1'b1;
    for (int n = 0; n < 3; n++) begin
      sb.push_back(exp_t'{GNT_IF, 1'b1, 8'hF9, cyc + 32'd6 + 32'(7 * n)});
    end
    for (int n = 0; n < 3; n++) begin
      wait_done_any(p);
      if (n == 2) begin
        drop_req(GNT_IF);
      end else begin
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0) begin
          errors++; $display("FAIL b2b_idle%0d: busy got %0b expected 0", n, bus.busy);
        end
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b1) begin
          errors++; $display("FAIL b2b_regrant%0d: busy got %0b expected 1", n, bus.busy);
        end
      end
    end
  endtask

  initial begin
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.mem_req = 1'b0; bus.mem_we = 1'b0; bus.mem_addr = '0; bus.mem_wdata = '0;
    bus.ram_dout = '0;

    test_reset();
    test_if_read();
    test_write_read();
    test_wrap();
    test_tie(GNT_MEM);
    single_read(GNT_MEM, 16'h0000, 8'hF9);
`ifdef MEM_ARB_RR_EN
    test_tie(GNT_IF);
`else
    test_tie(GNT_MEM);
`endif
    test_reset_midflight();
    test_back_to_back();

    repeat (10) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL sb_drain: %0d entries left expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_mem_arbiter
`default_nettype wire
